// File: rtl/fir_prod_accumulator.sv
// Sums TAPS unsigned tap products per output sample and presents the result on a valid/ready port.
// Build option: define FIR_ACC_SAT_EN to saturate y on overflow (default build wraps modulo 2^OUT_W).
module fir_prod_accumulator #(
  parameter int TAPS   = 3,
  parameter int PROD_W = 16,
  parameter int ACC_W  = 18,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [OUT_W-1:0]  y,
  output logic              ovf,
  output logic              state_dbg
);

  // Handshake: a beat transfers on a rising edge where valid && ready; a source never
  // withdraws data on ready, and y/ovf are held stable while y_valid && !y_ready.

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
  localparam logic [ACC_W-1:0] OUT_MAX  = ACC_W'({OUT_W{1'b1}});

  typedef enum logic {
    ACCUM = 1'b0,
    LAST  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tap_cnt_q, tap_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   sum;
  logic [OUT_W-1:0]   y_d;
  logic               ovf_d;
  logic               y_valid_d;
  logic               take;
  logic               load;

  assign state_dbg = state_q;

  always_comb begin
    sum        = acc_q + ACC_W'(prod);
    // Only the final tap can stall: it needs a free (or draining) output register.
    prod_ready = !flush && (state_q != LAST || !y_valid || y_ready);
    take       = prod_valid && prod_ready;
    load       = take && (state_q == LAST);

    state_d    = state_q;
    tap_cnt_d  = tap_cnt_q;
    acc_d      = acc_q;
    y_d        = y;
    ovf_d      = ovf;
    y_valid_d  = y_valid;

    if (flush) begin
      state_d   = ACCUM;
      tap_cnt_d = '0;
      acc_d     = '0;
    end else if (take) begin
      if (state_q == LAST) begin
        state_d   = ACCUM;
        tap_cnt_d = '0;
        acc_d     = '0;
      end else begin
        acc_d     = (tap_cnt_q == '0) ? ACC_W'(prod) : sum;
        tap_cnt_d = tap_cnt_q + CNT_W'(1);
        state_d   = (tap_cnt_d == LAST_TAP) ? LAST : ACCUM;
      end
    end

    if (load) begin
      y_valid_d = 1'b1;
      ovf_d     = (sum > OUT_MAX);
`ifdef FIR_ACC_SAT_EN
      y_d       = (sum > OUT_MAX) ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
`else
      y_d       = sum[OUT_W-1:0];
`endif
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      tap_cnt_q <= '0;
      acc_q     <= '0;
      y         <= '0;
      ovf       <= 1'b0;
      y_valid   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      acc_q     <= acc_d;
      y         <= y_d;
      ovf       <= ovf_d;
      y_valid   <= y_valid_d;
    end
  end

endmodule

// File: doc/fir_prod_accumulator.md
# fir_prod_accumulator

Accumulates the unsigned 16-bit tap products of the FIR datapath and emits one filter output per input sample. It sits directly downstream of the 8x8 Dadda tap multipliers and consumes one product per cycle. After `TAPS` products it registers the sum and presents it on a valid/ready output port. The block stalls its product input only when a completed result cannot be stored.

## Interface
Parameters:
- `TAPS`, default 3: products summed per output sample; must be ≥ 2.
- `PROD_W`, default 16: product width, matching the multiplier output.
- `ACC_W`, default 18: accumulator width; must satisfy `ACC_W ≥ PROD_W + ceil(log2(TAPS))`.
- `OUT_W`, default 16: output sample width; must satisfy `OUT_W ≤ ACC_W`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of the partial sum.
- `prod_valid`  in  1  `prod` holds a valid tap product.
- `prod`  in  `PROD_W`  unsigned tap product, tap 0 first.
- `prod_ready`  out  1  block accepts `prod` this cycle.
- `y_valid`  out  1  `y`/`ovf` hold a completed sample.
- `y_ready`  in  1  downstream accepts `y` this cycle.
- `y`  out  `OUT_W`  filter output sample.
- `ovf`  out  1  completed sum exceeded `2^OUT_W-1`.

## Operation
- **Product transfer:** a product is accepted when `prod_valid && prod_ready`. An output is consumed when `y_valid && y_ready`.
- **Internal state:**
  - `tap_cnt`: range 0..`TAPS-1`.
  - `acc`: `ACC_W` bits.
  - Output register: `y`, `ovf`, `y_valid`.
- **FSM states:**
  - ACCUM: `tap_cnt < TAPS-1`.
  - LAST: `tap_cnt == TAPS-1`.
  - Output-register occupancy is tracked separately by `y_valid`.
- **Accepting product with `tap_cnt == 0`:** `acc <= prod` (zero-extended), `tap_cnt <= 1`.
- **Accepting product with `0 < tap_cnt < TAPS-1`:** `acc <= acc + prod`, `tap_cnt++`.
- **Accepting product in LAST:**
  - `sum = acc + prod`.
  - Output register loads `sum` (per Configuration) and `ovf <= (sum ≥ 2^OUT_W)`.
  - `y_valid <= 1`, `tap_cnt <= 0`.
- **Ready logic:** `prod_ready = !flush && (tap_cnt != TAPS-1 || !y_valid || y_ready)`.
  - Partial taps always flow.
  - Only the final tap stalls when the output register is full and not draining.
- **Output register:**
  - When the output is consumed and no new result is loaded in the same cycle: `y_valid <= 0`; `y` and `ovf` hold their values.
  - When the output is consumed and a new result is loaded in the same cycle: the new result is loaded and `y_valid` stays 1.
- **Flush:**
  - `flush` forces `tap_cnt <= 0` and `acc <= 0`; it wins over a simultaneous `prod_valid`, and that product is dropped.
  - `flush` does not touch the output register or `y_valid`.
- **Arithmetic:** unsigned; `ACC_W` sizing guarantees no internal wrap.

## Timing
- **Reset values** (asynchronous, `rst_n` low): `y_valid=0`, `y=0`, `ovf=0`, `tap_cnt=0`, `acc=0`. Because `tap_cnt=0`, `prod_ready=1` during and after reset.
- **Reset mid-sequence:** discards the partial sum and any undrained output; the first product after release is tap 0.
- **Latency:** `y_valid` rises the cycle after the final tap is accepted.
- **Throughput:** one product per cycle. With `y_ready` held high and continuous `prod_valid`, `y_valid` pulses once every `TAPS` cycles.
- **Holding rules:**
  - `y` and `ovf` are stable while `y_valid && !y_ready`.
  - `prod` need not be held once accepted.
- **Stall release:** a final tap stalled in LAST is accepted in the same cycle `y_ready` rises.

## Configuration
- `FIR_ACC_SAT_EN` defined: `y = (sum ≥ 2^OUT_W) ? {OUT_W{1'b1}} : sum[OUT_W-1:0]` (saturating).
- `FIR_ACC_SAT_EN` undefined: `y = sum[OUT_W-1:0]` (modular wrap).
- `ovf` behaves identically in both builds.

## Test plan
All scenarios use default parameters.
- **Basic sum:** reset, then `y_ready=1` and products 100, 200, 300 on consecutive cycles -> `y=600`, `ovf=0`, `y_valid` high exactly one cycle, one cycle after the 300 is accepted.
- **Overflow:** products 65535 ×3 (sum 196605) -> `ovf=1`. With `FIR_ACC_SAT_EN`, `y=65535`; without it, `y=65533`.
- **Backpressure:**
  - Setup: `y_ready=0`; sequence 1,2,3 then 4,5,6.
  - Required: `y=6` is held; taps 4 and 5 are accepted and `prod_ready=0` with 6 pending.
  - Release: `y_ready=1` for one cycle -> 6 is accepted that cycle and `y=15` follows on the next cycle.
- **Flush:**
  - Products 10, 20, then `flush` together with `prod_valid` and 999 (dropped), then 1, 2, 3 -> `y=6`.
  - A previously pending `y` stays valid throughout.
- **Async reset mid-sequence:** assert `rst_n=0` between taps 1 and 2 with a `y` pending -> all outputs are 0 immediately; after release, 7, 8, 9 -> `y=24`.
- **Streaming:** 30 continuous random products with `y_ready=1` -> 10 outputs, each matching a reference model, with no `prod_ready` deassertion.
